control_unit: RTL and testbench

- Instruction-driven control unit. Consumes one 3-bit opcode per clock from the instruction memory read port and drives a 13-bit accumulator output.
- The output feeds the data-memory write port in the enclosing memory controller.
- Small FSM: single-cycle ALU ops, a multi-cycle load-immediate that collects operand words from the same instruction stream, and a halt state.

---
 rtl/control_unit.sv | 97 +++++++++
 tb/tb_control_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Instruction-driven accumulator FSM: single-cycle ALU ops, multi-word LOADI, HALT.
// Optional macro CONTROL_UNIT_SAT_EN makes INC/DEC saturate instead of wrap.
module control_unit #(
  parameter int unsigned DW       = 13,
  parameter int unsigned IW       = 3,
  parameter int unsigned LD_WORDS = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] in,
  output logic [DW-1:0] o
);

  localparam int unsigned SW = LD_WORDS * IW;
  localparam int unsigned CW = (LD_WORDS > 1) ? $clog2(LD_WORDS) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(LD_WORDS - 1);
  localparam logic [DW-1:0] One = DW'(1);

  localparam logic [IW-1:0] OpNop   = IW'(0);
  localparam logic [IW-1:0] OpInc   = IW'(1);
  localparam logic [IW-1:0] OpDec   = IW'(2);
  localparam logic [IW-1:0] OpShl   = IW'(3);
  localparam logic [IW-1:0] OpShr   = IW'(4);
  localparam logic [IW-1:0] OpNot   = IW'(5);
  localparam logic [IW-1:0] OpLoadi = IW'(6);
  localparam logic [IW-1:0] OpHalt  = IW'(7);

  typedef enum logic [1:0] {
    StExec = 2'd0,
    StLoad = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e        r_state;
  logic [DW-1:0] r_o;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_shift;

  logic [SW-1:0] w_shift_next;
  logic [DW-1:0] w_load;
  logic [DW-1:0] w_inc;
  logic [DW-1:0] w_dec;

  // MSB-first assembly; excess high bits fall off the top.
  assign w_shift_next = SW'({r_shift, in});
  assign w_load       = DW'({r_shift, in});

`ifdef CONTROL_UNIT_SAT_EN
  assign w_inc = (&r_o) ? r_o : r_o + One;
  assign w_dec = (~|r_o) ? r_o : r_o - One;
`else
  assign w_inc = r_o + One;
  assign w_dec = r_o - One;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StExec;
      r_o     <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        StExec: begin
          case (in)
            OpNop:   r_o <= r_o;
            OpInc:   r_o <= w_inc;
            OpDec:   r_o <= w_dec;
            OpShl:   r_o <= {r_o[DW-2:0], 1'b0};
            OpShr:   r_o <= {1'b0, r_o[DW-1:1]};
            OpNot:   r_o <= ~r_o;
            OpLoadi: begin
              r_state <= StLoad;
              r_cnt   <= '0;
              r_shift <= '0;
            end
            OpHalt:  r_state <= StHalt;
            default: r_o <= r_o;
          endcase
        end
        StLoad: begin
          r_shift <= w_shift_next;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LastCnt) begin
            r_o     <= w_load;
            r_state <= StExec;
          end
        end
        StHalt:  r_state <= StHalt;
        default: r_state <= StExec;
      endcase
    end
  end

  assign o = r_o;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a reference model pushes expected o per cycle.
module tb_control_unit;

  localparam int DW = 13;
  localparam int IW = 3;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] in_w = '0;
  logic [DW-1:0] o;

  control_unit #(.DW(DW), .IW(IW), .LD_WORDS(LW)) dut (
    .clk(clk),
    .rst(rst),
    .in (in_w),
    .o  (o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb_q[$];

  // Reference model state: 0 exec, 1 load, 2 halt
  int             m_st  = 0;
  logic [DW-1:0]  m_o   = '0;
  int             m_cnt = 0;
  logic [LW*IW-1:0] m_sh = '0;

  // Drive one cycle, update the model, push the expectation, land #1 after the edge.
  task automatic drive(input logic r, input logic [IW-1:0] op);
    rst  = r;
    in_w = op;
    if (r) begin
      m_st = 0; m_o = '0; m_cnt = 0; m_sh = '0;
    end else if (m_st == 0) begin
      case (op)
`ifdef CONTROL_UNIT_SAT_EN
        3'd1: if (m_o != {DW{1'b1}}) m_o = m_o + 1'b1;
        3'd2: if (m_o != '0) m_o = m_o - 1'b1;
`else
        3'd1: m_o = m_o + 1'b1;
        3'd2: m_o = m_o - 1'b1;
`endif
        3'd3: m_o = m_o << 1;
        3'd4: m_o = m_o >> 1;
        3'd5: m_o = ~m_o;
        3'd6: begin m_st = 1; m_cnt = 0; m_sh = '0; end
        3'd7: m_st = 2;
        default: ;
      endcase
    end else if (m_st == 1) begin
      m_sh = {m_sh[LW*IW-IW-1:0], op};
      m_cnt++;
      if (m_cnt == LW) begin
        m_o  = m_sh[DW-1:0];
        m_st = 0;
      end
    end
    sb_q.push_back(m_o);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] e;
    drive(1'b1, 3'd5);
    e = sb_q.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL reset_sb: o=%0d expected %0d", o, e); end
    n_checks++;
    if (o !== 13'd0) begin n_fail++; $display("FAIL reset_zero: o=%0d expected 0", o); end
  endtask

  task automatic test_inc_dec();
    logic [DW-1:0] e;
    drive(1'b1, 3'd0); void'(sb_q.pop_front());
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, (i < 10) ? 3'd1 : (i < 14) ? 3'd2 : 3'd0);
      e = sb_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL inc_dec[%0d]: o=%0d expected %0d", i, o, e); end
      if (i == 9) begin
        n_checks++;
        if (o !== 13'd10) begin n_fail++; $display("FAIL inc_to_10: o=%0d expected 10", o); end
      end
    end
    n_checks++;
    if (o !== 13'd6) begin n_fail++; $display("FAIL dec_nop_6: o=%0d expected 6", o); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] e;
    logic [IW-1:0] seq [7];
    seq = '{3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd1};
    drive(1'b1, 3'd0); void'(sb_q.pop_front());
    drive(1'b0, 3'd2);
    e = sb_q.pop_front();
    n_checks++;
`ifdef CONTROL_UNIT_SAT_EN
    if (o !== 13'd0 || o !== e) begin n_fail++; $display("FAIL dec_floor: o=%0d expected 0", o); end
`else
    if (o !== 13'd8191 || o !== e) begin
      n_fail++; $display("FAIL dec_wrap: o=%0d expected 8191", o);
    end
`endif
    drive(1'b1, 3'd0); void'(sb_q.pop_front());
    foreach (seq[i]) begin
      drive(1'b0, seq[i]);
      e = sb_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_seq[%0d]: o=%0d expected %0d", i, o, e); end
      if (i == 5) begin
        n_checks++;
        if (o !== 13'd8191) begin n_fail++; $display("FAIL loadi_max: o=%0d expected 8191", o); end
      end
    end
    n_checks++;
`ifdef CONTROL_UNIT_SAT_EN
    if (o !== 13'd8191) begin n_fail++; $display("FAIL inc_ceiling: o=%0d expected 8191", o); end
`else
    if (o !== 13'd0) begin n_fail++; $display("FAIL inc_wrap: o=%0d expected 0", o); end
`endif
  endtask

  task automatic test_loadi_alu();
    logic [DW-1:0] e;
    logic [IW-1:0] seq [9];
    logic [DW-1:0] want [9];
    seq  = '{3'd6, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd3, 3'd4, 3'd5};
    want = '{13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd4095, 13'd8190, 13'd4095, 13'd4096};
    drive(1'b1, 3'd0); void'(sb_q.pop_front());
    foreach (seq[i]) begin
      drive(1'b0, seq[i]);
      e = sb_q.pop_front();
      n_checks++;
      if (o !== e || o !== want[i]) begin
        n_fail++; $display("FAIL loadi_alu[%0d]: o=%0d expected %0d", i, o, want[i]);
      end
    end
  endtask

  task automatic test_load_abort();
    logic [DW-1:0] e;
    logic [IW-1:0] seq [5];
    logic          rs  [5];
    logic [DW-1:0] want [5];
    drive(1'b1, 3'd0); void'(sb_q.pop_front());
    drive(1'b0, 3'd1); void'(sb_q.pop_front());  // o=1 so a mid-load reset is visible
    seq  = '{3'd6, 3'd1, 3'd1, 3'd1, 3'd1};
    rs   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    want = '{13'd1, 13'd1, 13'd1, 13'd0, 13'd1};
    foreach (seq[i]) begin
      drive(rs[i], seq[i]);
      e = sb_q.pop_front();
      n_checks++;
      if (o !== e || o !== want[i]) begin
        n_fail++; $display("FAIL load_abort[%0d]: o=%0d expected %0d", i, o, want[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [DW-1:0] e;
    logic [IW-1:0] seq [10];
    logic          rs  [10];
    logic [DW-1:0] want [10];
    seq  = '{3'd1, 3'd1, 3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    rs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    want = '{13'd1, 13'd2, 13'd2, 13'd2, 13'd2, 13'd2, 13'd2, 13'd2, 13'd0, 13'd1};
    drive(1'b1, 3'd0); void'(sb_q.pop_front());
    foreach (seq[i]) begin
      drive(rs[i], seq[i]);
      e = sb_q.pop_front();
      n_checks++;
      if (o !== e || o !== want[i]) begin
        n_fail++; $display("FAIL halt[%0d]: o=%0d expected %0d", i, o, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    logic          r;
    drive(1'b1, 3'd0); void'(sb_q.pop_front());
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 29) == 0);
      drive(r, IW'($urandom_range(0, 7)));
      e = sb_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random[%0d]: o=%0d expected %0d", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_inc_dec();
    test_wrap();
    test_loadi_alu();
    test_load_abort();
    test_halt();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
